branch_redirect_arbiter: RTL
============================

# branch_redirect_arbiter

Collects branch-resolution requests from the VLIW execute lanes and an external redirect source, and selects one winner per redirect. Drives the program counter's `branch_taken`/`new_pc` inputs. After each redirect it enforces a wrong-path shadow, dropping branch requests from bundles already in flight. Sits between the per-lane branch execute units and the program counter; keeps performance counters for taken and dropped branches.

## Interface
- `NUM_LANES`, 4: number of issue lanes that can resolve a branch.
- `SHADOW_CYCLES`, 2: cycles after the issue cycle during which lane requests are wrong-path and dropped. Legal range 1..7.
- `clk` input, 1: single clock, all state on rising edge.
- `rst` input, 1: asynchronous, active-high reset.
- `br_valid` input, NUM_LANES: lane i resolved a taken branch this cycle.
- `br_target` input, NUM_LANES x 32: target address for lane i.
- `ext_valid` input, 1: external redirect (trap/restart) request.
- `ext_target` input, 32: external redirect address.
- `branch_taken` output, 1: one-cycle redirect strobe to the program counter.
- `new_pc` output, 32: redirect address, valid when `branch_taken`=1.
- `busy` output, 1: high in ISSUE and SHADOW.
- `misalign_err` output, 1: sticky; set when any accepted target has bits [3:0] ≠ 0.
- `taken_count` output, 32: accepted redirects (lane and external), wraps.
- `dropped_count` output, 32: lane requests discarded (shadow losers and non-winning lanes), wraps.

## Operation
- FSM states: IDLE, ISSUE, SHADOW.
- **IDLE:**
  - If `ext_valid`=1, accept `ext_target`.
  - Else if any `br_valid` bit is set, accept the lowest-index valid lane. The lowest lane is the earliest instruction in the bundle.
  - On accept: register the target into `new_pc` and go to ISSUE.
- **ISSUE:** `branch_taken`=1 for exactly this cycle. Load the shadow counter with SHADOW_CYCLES and go to SHADOW.
- **SHADOW:** decrement the counter each cycle. When the counter reaches 1 and decrements, go to IDLE.
- **Dropping:** all `br_valid` bits in ISSUE and SHADOW are dropped.
- **External redirect during ISSUE/SHADOW:** `ext_valid` is accepted in any state.
  - In ISSUE or SHADOW: latch `ext_target` and go to ISSUE next cycle. This restarts the shadow.
  - Simultaneous lane requests are dropped.
- **Target alignment:** accepted targets are forced to a 16-byte bundle boundary. `new_pc` = target & 32'hFFFF_FFF0. If the original bits [3:0] were nonzero, set `misalign_err`; it is cleared only by `rst`.
- **Counters:**
  - `taken_count` +1 per accept.
  - `dropped_count` += popcount of dropped `br_valid` bits each cycle. This includes losing lanes in the same cycle as a lane accept.
  - Both counters wrap modulo 2^32.
- **Reset values:** state IDLE, `branch_taken`=0, `new_pc`=32'h0, `busy`=0, `misalign_err`=0, both counters 0, shadow counter 0.
  - Reset mid-SHADOW abandons the redirect immediately.

## Timing
- **Latency:**
  - Request sampled at the end of cycle n.
  - `branch_taken`/`new_pc` asserted in cycle n+1.
  - PC loads at the end of n+1; the target instruction is at decode in n+3.
- **Drop window:** ISSUE plus SHADOW spans 1+SHADOW_CYCLES cycles (n+1 .. n+1+SHADOW_CYCLES).
- **First re-accept:** IDLE resumes in cycle n+2+SHADOW_CYCLES, and lane requests are accepted in that same cycle.
- **No back-to-back strobes from lanes:** back-to-back `branch_taken` can occur only via `ext_valid`.
- **Output registration:** all outputs are registered; there is no combinational path from inputs to `branch_taken`.

## Structure
- **Shared package `vliw_pkg`:**
  - `NUM_LANES`
  - bundle byte size (16)
  - reset vector 32'h0040_0020
  - enum `redir_state_t` {IDLE, ISSUE, SHADOW}
- **Sub-module `lane_priority_enc`:** combinational lowest-index select. Outputs the one-hot grant, the index, and the popcount of the losers. Parameterised by NUM_LANES.

## Test plan
- **Single lane branch:**
  - Stimulus: reset; cycle 5 `br_valid`=4'b0100, lane2 target 32'h0040_0100.
  - Response: cycle 6 `branch_taken`=1, `new_pc`=32'h0040_0100; `taken_count`=1; `busy` high cycles 6–8.
- **Multi-lane conflict:**
  - Stimulus: `br_valid`=4'b1010, targets lane1=0x500, lane3=0x600.
  - Response: `new_pc`=0x500; `dropped_count`=1.
- **Shadow drop:**
  - Stimulus: accept in cycle n; `br_valid`=4'b0001 in n+1, n+2, n+3.
  - Response: no further strobe; `dropped_count`=3.
  - Stimulus: request in n+4.
  - Response: strobe in n+5.
- **External redirect during SHADOW:**
  - Stimulus: `ext_valid` with 0x0040_0020 in n+2; lane0 valid in n+2.
  - Response: strobe in n+3 with 0x0040_0020; shadow restarts; `taken_count`=2; `dropped_count`=1.
- **Misaligned target:**
  - Stimulus: lane0 target 0x0040_0104.
  - Response: `new_pc`=0x0040_0100; `misalign_err`=1, held until `rst`.
- **Reset mid-operation:**
  - Stimulus: assert `rst` asynchronously during SHADOW.
  - Response: all outputs zero immediately; a lane request one cycle after deassert yields a strobe the following cycle.

Source files
------------

// File: rtl/vliw_pkg.sv
// Shared definitions for the VLIW front-end redirect logic.
//   NUM_LANES     - issue lanes that can resolve a branch
//   BUNDLE_BYTES  - fetch bundle size; redirect targets align to it
//   BUNDLE_MASK   - AND mask that forces an address to a bundle boundary
//   RESET_VECTOR  - architectural restart address
//   redir_state_t - redirect arbiter FSM states
package vliw_pkg;

  localparam int unsigned NUM_LANES    = 4;
  localparam int unsigned BUNDLE_BYTES = 16;
  localparam logic [31:0] BUNDLE_MASK  = ~(32'(BUNDLE_BYTES) - 32'd1);
  localparam logic [31:0] RESET_VECTOR = 32'h0040_0020;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    SHADOW
  } redir_state_t;

endpackage

// File: rtl/lane_priority_enc.sv
// Combinational lowest-index selector for lane branch requests.
// The lowest lane holds the earliest instruction of the bundle.
//   valid_i     - per-lane request bits
//   grant_o     - one-hot grant of the lowest valid lane ('0 when none)
//   idx_o       - index of the granted lane (0 when none)
//   loser_cnt_o - number of valid lanes that did not win
module lane_priority_enc #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1,
  parameter int unsigned CNT_W = $clog2(N + 1)
) (
  input  logic [N-1:0]     valid_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic [CNT_W-1:0] loser_cnt_o
);

  logic             found;
  logic [CNT_W-1:0] pop;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    pop     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      pop = pop + CNT_W'(valid_i[i]);
      if (valid_i[i] && !found) begin
        grant_o[i] = 1'b1;
        idx_o      = IDX_W'(i);
        found      = 1'b1;
      end
    end
    loser_cnt_o = pop - CNT_W'(found);
  end

endmodule

// File: rtl/branch_redirect_arbiter.sv
// Selects one redirect per window from the lane branch units and the
// external (trap/restart) source, strobes the program counter, and masks
// wrong-path lane requests for SHADOW_CYCLES cycles after each strobe.
//   clk, rst      - clock, asynchronous active-high reset
//   br_valid      - per-lane taken-branch request
//   br_target     - per-lane target, lane i in bits [32*i +: 32]
//   ext_valid     - external redirect request (accepted in every state)
//   ext_target    - external redirect address
//   branch_taken  - one-cycle redirect strobe
//   new_pc        - bundle-aligned redirect address
//   busy          - high during ISSUE and SHADOW
//   misalign_err  - sticky: an accepted target had sub-bundle bits set
//   taken_count   - accepted redirects (wraps)
//   dropped_count - discarded lane requests (wraps)
module branch_redirect_arbiter
  import vliw_pkg::*;
#(
  parameter int unsigned NUM_LANES     = vliw_pkg::NUM_LANES,
  parameter int unsigned SHADOW_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_LANES-1:0]   br_valid,
  input  logic [NUM_LANES*32-1:0] br_target,
  input  logic                   ext_valid,
  input  logic [31:0]            ext_target,
  output logic                   branch_taken,
  output logic [31:0]            new_pc,
  output logic                   busy,
  output logic                   misalign_err,
  output logic [31:0]            taken_count,
  output logic [31:0]            dropped_count
);

  localparam int unsigned IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int unsigned CNT_W = $clog2(NUM_LANES + 1);

  redir_state_t     state_q, state_d;
  logic [2:0]       shadow_q, shadow_d;
  logic             taken_q, taken_d;
  logic [31:0]      pc_q, pc_d;
  logic             busy_q, busy_d;
  logic             mis_q, mis_d;
  logic [31:0]      tcnt_q, tcnt_d;
  logic [31:0]      dcnt_q, dcnt_d;

  logic [NUM_LANES-1:0] grant;
  logic [IDX_W-1:0]     win_idx;
  logic [CNT_W-1:0]     loser_cnt;
  logic                 lane_any;
  logic [CNT_W-1:0]     pop_all;
  logic [31:0]          tgt_arr [NUM_LANES];
  logic [31:0]          lane_tgt;

  logic                 accept;
  logic [31:0]          acc_tgt;
  logic [CNT_W-1:0]     drop;

  lane_priority_enc #(
    .N     (NUM_LANES),
    .IDX_W (IDX_W),
    .CNT_W (CNT_W)
  ) u_prio (
    .valid_i     (br_valid),
    .grant_o     (grant),
    .idx_o       (win_idx),
    .loser_cnt_o (loser_cnt)
  );

  assign lane_any = |grant;
  // Winner plus losers gives every requesting lane, used when all are dropped.
  assign pop_all  = loser_cnt + CNT_W'(lane_any);

  always_comb begin
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      tgt_arr[i] = br_target[32*i +: 32];
    end
    lane_tgt = tgt_arr[win_idx];
  end

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    accept   = 1'b0;
    acc_tgt  = '0;
    drop     = '0;

    case (state_q)
      IDLE: begin
        if (ext_valid) begin
          accept  = 1'b1;
          acc_tgt = ext_target;
          drop    = pop_all;
          state_d = ISSUE;
        end else if (lane_any) begin
          accept  = 1'b1;
          acc_tgt = lane_tgt;
          drop    = loser_cnt;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        drop = pop_all;
        if (ext_valid) begin
          accept  = 1'b1;
          acc_tgt = ext_target;
          state_d = ISSUE;
        end else begin
          shadow_d = 3'(SHADOW_CYCLES);
          state_d  = SHADOW;
        end
      end
      SHADOW: begin
        drop = pop_all;
        if (ext_valid) begin
          accept  = 1'b1;
          acc_tgt = ext_target;
          state_d = ISSUE;
        end else begin
          shadow_d = shadow_q - 3'd1;
          if (shadow_q <= 3'd1) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    pc_d   = pc_q;
    mis_d  = mis_q;
    tcnt_d = tcnt_q;
    if (accept) begin
      pc_d   = acc_tgt & BUNDLE_MASK;
      mis_d  = mis_q | (|(acc_tgt & ~BUNDLE_MASK));
      tcnt_d = tcnt_q + 32'd1;
    end
    dcnt_d = dcnt_q + 32'(drop);

    // Outputs are registered copies of the next state's decode.
    taken_d = (state_d == ISSUE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      taken_q  <= 1'b0;
      pc_q     <= '0;
      busy_q   <= 1'b0;
      mis_q    <= 1'b0;
      tcnt_q   <= '0;
      dcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      taken_q  <= taken_d;
      pc_q     <= pc_d;
      busy_q   <= busy_d;
      mis_q    <= mis_d;
      tcnt_q   <= tcnt_d;
      dcnt_q   <= dcnt_d;
    end
  end

  assign branch_taken  = taken_q;
  assign new_pc        = pc_q;
  assign busy          = busy_q;
  assign misalign_err  = mis_q;
  assign taken_count   = tcnt_q;
  assign dropped_count = dcnt_q;

endmodule
